// File: rtl/dht11_sensor_model.sv
// DHT11 sensor emulator: answers a host start pulse on the open-drain bus with the
// response preamble and a 40-bit humidity/temperature frame, MSB first.
module dht11_sensor_model #(
    parameter int CLK_PER_US   = 100,
    parameter int START_MIN_US = 18000,
    parameter int RESP_WAIT_US = 20,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 27,
    parameter int BIT1_HIGH_US = 70,
    parameter int END_LOW_US   = 50
) (
    input  logic       clk,
    input  logic       reset_p,
    inout  wire        dht11_data,
    input  logic [7:0] humidity_in,
    input  logic [7:0] temperature_in,
    output logic       busy,
    output logic       frame_done
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_US = max_of(max_of(max_of(START_MIN_US, RESP_WAIT_US),
                                          max_of(RESP_LOW_US, RESP_HIGH_US)),
                                   max_of(max_of(BIT_LOW_US, BIT0_HIGH_US),
                                          max_of(BIT1_HIGH_US, END_LOW_US)));
    localparam int US_W = $clog2(MAX_US + 1);
    localparam int PS_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [US_W-1:0] START_CNT = US_W'(START_MIN_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_LOW,
        S_WAIT,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } state_t;

    state_t            state;
    logic [1:0]        sync;
    logic              din_s;
    logic              drive_low;
    logic [PS_W-1:0]   presc;
    logic              us_tick;
    logic [US_W-1:0]   us_cnt;
    logic [US_W-1:0]   phase_len_m1;
    logic              phase_end;
    logic              leave;
    logic [5:0]        idx;
    logic [39:0]       frame;
    logic [7:0]        checksum;

    assign dht11_data = drive_low ? 1'b0 : 1'bz;
    assign din_s      = sync[1];
    assign us_tick    = (presc == PS_W'(CLK_PER_US - 1));
    assign checksum   = humidity_in + temperature_in;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        phase_len_m1 = '0;
        case (state)
            S_WAIT:      phase_len_m1 = US_W'(RESP_WAIT_US - 1);
            S_RESP_LOW:  phase_len_m1 = US_W'(RESP_LOW_US - 1);
            S_RESP_HIGH: phase_len_m1 = US_W'(RESP_HIGH_US - 1);
            S_BIT_LOW:   phase_len_m1 = US_W'(BIT_LOW_US - 1);
            S_BIT_HIGH:  phase_len_m1 = frame[idx] ? US_W'(BIT1_HIGH_US - 1)
                                                   : US_W'(BIT0_HIGH_US - 1);
            S_END_LOW:   phase_len_m1 = US_W'(END_LOW_US - 1);
            default:     phase_len_m1 = '0;
        endcase
    end

    assign phase_end = us_tick && (us_cnt == phase_len_m1);
    // Any state exit clears the timebase so each phase is an exact multiple of CLK_PER_US.
    assign leave = (state == S_IDLE)     ? !din_s :
                   (state == S_HOST_LOW) ? din_s  : phase_end;

    // NOTE: drive_low sits in the async-reset branch, so reset releases the bus without a clock edge.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state      <= S_IDLE;
            sync       <= 2'b11;
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            idx        <= '0;
            us_cnt     <= '0;
            presc      <= '0;
            frame      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            sync       <= {sync[0], dht11_data};
            frame_done <= 1'b0;

            if (leave) begin
                presc  <= '0;
                us_cnt <= '0;
            end else if (state != S_IDLE) begin
                presc <= us_tick ? '0 : presc + 1'b1;
                if (us_tick && !(state == S_HOST_LOW && us_cnt == START_CNT))
                    us_cnt <= us_cnt + 1'b1;
            end

            case (state)
                S_IDLE: if (!din_s) state <= S_HOST_LOW;
                S_HOST_LOW: begin
                    if (din_s) begin
                        if (us_cnt >= START_CNT) begin
                            frame <= {humidity_in, 8'd0, temperature_in, 8'd0, checksum};
                            busy  <= 1'b1;
                            state <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_WAIT: if (phase_end) begin
                    state     <= S_RESP_LOW;
                    drive_low <= 1'b1;
                end
                S_RESP_LOW: if (phase_end) begin
                    state     <= S_RESP_HIGH;
                    drive_low <= 1'b0;
                end
                S_RESP_HIGH: if (phase_end) begin
                    idx       <= 6'd39;
                    state     <= S_BIT_LOW;
                    drive_low <= 1'b1;
                end
                S_BIT_LOW: if (phase_end) begin
                    state     <= S_BIT_HIGH;
                    drive_low <= 1'b0;
                end
                S_BIT_HIGH: if (phase_end) begin
                    drive_low <= 1'b1;
                    if (idx != 6'd0) begin
                        idx   <= idx - 6'd1;
                        state <= S_BIT_LOW;
                    end else begin
                        state <= S_END_LOW;
                    end
                end
                S_END_LOW: if (phase_end) begin
                    state      <= S_IDLE;
                    drive_low  <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    drive_low <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Randomised scoreboard bench for dht11_sensor_model: a host model issues start pulses,
// a bus monitor decodes the response and checks timing and frame content.
module tb_dht11_sensor_model;

    localparam int P     = 2;
    localparam int START = 100;
    localparam int RW    = 20;
    localparam int RL    = 80;
    localparam int RH    = 80;
    localparam int BL    = 50;
    localparam int B0    = 27;
    localparam int B1    = 70;
    localparam int EL    = 50;
    localparam int RUN_LIMIT = 20000;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] humidity_in = 8'd0;
    logic [7:0] temperature_in = 8'd0;
    logic       busy;
    logic       frame_done;
    wire        dht11_data;

    pullup (dht11_data);
    assign dht11_data = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_sensor_model #(
        .CLK_PER_US  (P),
        .START_MIN_US(START),
        .RESP_WAIT_US(RW),
        .RESP_LOW_US (RL),
        .RESP_HIGH_US(RH),
        .BIT_LOW_US  (BL),
        .BIT0_HIGH_US(B0),
        .BIT1_HIGH_US(B1),
        .END_LOW_US  (EL)
    ) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .dht11_data    (dht11_data),
        .humidity_in   (humidity_in),
        .temperature_in(temperature_in),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [39:0] exp_q[$];
    int          bits_seen = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          fd_run = 0;
    logic        prev_busy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference frame straight from the sensor's data format.
    function automatic logic [39:0] model_frame(input logic [7:0] h, input logic [7:0] t);
        int sum;
        sum = (int'(h) + int'(t)) % 256;
        return {h, 8'd0, t, 8'd0, 8'(sum)};
    endfunction

    // Length of the bus run at level lvl, the current sample already counted.
    task automatic run_from(input logic lvl, output int len, output bit ab);
        len = 1;
        ab  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_p) begin
                ab = 1'b1;
                return;
            end
            if (dht11_data !== lvl || len >= RUN_LIMIT) return;
            len++;
        end
    endtask

    task automatic phase(input logic lvl, input int exp_len, input string name,
                         output int len, inout bit ab);
        len = 0;
        if (ab) return;
        run_from(lvl, len, ab);
        if (!ab && exp_len > 0) check(name, len, exp_len);
    endtask

    // Bus monitor / scoreboard consumer.
    initial begin : monitor
        logic [39:0] got;
        logic [39:0] exp;
        logic        bit_v;
        int          len;
        bit          ab;
        forever begin
            @(negedge clk);
            if (reset_p || !busy) continue;
            bits_seen = 0;
            got = '0;
            ab  = 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
                exp = '0;
            end else begin
                exp = exp_q[0];
            end
            check("bus_high_at_wait", dht11_data, 1);
            phase(1'b1, RW * P, "resp_wait_len", len, ab);
            phase(1'b0, RL * P, "resp_low_len", len, ab);
            phase(1'b1, RH * P, "resp_high_len", len, ab);
            for (int b = 39; b >= 0; b--) begin
                phase(1'b0, BL * P, "bit_low_len", len, ab);
                phase(1'b1, (exp[b] ? B1 : B0) * P, "bit_high_len", len, ab);
                if (ab) break;
                bit_v = (len > ((B0 + B1) * P) / 2);
                got   = {got[38:0], bit_v};
                bits_seen++;
            end
            phase(1'b0, EL * P, "end_low_len", len, ab);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (!ab) begin
                check("frame", got, exp);
                check("checksum", got[7:0], exp[7:0]);
            end
        end
    end

    // frame_done pulse shape and its alignment with busy.
    always @(negedge clk) begin
        if (reset_p) begin
            fd_run = 0;
        end else if (frame_done) begin
            fd_run++;
            if (fd_run == 1) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
                check("busy_high_before_done", prev_busy, 1);
                check("bus_released_at_done", dht11_data, 1);
            end
        end else begin
            if (fd_run > 0) check("frame_done_width", fd_run, 1);
            fd_run = 0;
        end
        prev_busy = busy;
    end

    task automatic host_start(input int low_cycles);
        @(posedge clk);
        #1 host_low = 1'b1;
        repeat (low_cycles) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string name);
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            if (done_cnt > prev) break;
        end
        check(name, (done_cnt > prev), 1);
        repeat (20) @(posedge clk);
    endtask

    task automatic wait_bits(input int n, input string name);
        int i;
        for (i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (bits_seen >= n && busy) break;
        end
        check(name, (i < 30000), 1);
    endtask

    task automatic do_frame(input logic [7:0] h, input logic [7:0] t);
        int prev;
        humidity_in    = h;
        temperature_in = t;
        exp_q.push_back(model_frame(h, t));
        prev = done_cnt;
        host_start(2 * START * P);
        wait_done(prev, "frame_done_seen");
        exp_done++;
    endtask

    initial begin : stimulus
        int  prev;
        bit  bad;
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_bus_released", dht11_data, 1);
        @(posedge clk);
        #1 reset_p = 1'b0;
        repeat (5) @(posedge clk);

        // Nominal and checksum wrap.
        do_frame(8'd70, 8'd25);
        do_frame(8'd200, 8'd100);

        // Short start pulse must be ignored.
        prev = done_cnt;
        host_start(START * P / 2);
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (busy || dht11_data !== 1'b1) bad = 1'b1;
        end
        check("short_start_ignored", bad, 0);
        check("short_start_no_done", done_cnt, prev);

        // Inputs change mid-frame; the latched snapshot is what goes out.
        humidity_in    = 8'd70;
        temperature_in = 8'd25;
        exp_q.push_back(model_frame(8'd70, 8'd25));
        prev = done_cnt;
        host_start(2 * START * P);
        wait_bits(9, "reach_bit30");
        humidity_in = 8'd33;
        wait_done(prev, "snapshot_done_seen");
        exp_done++;
        do_frame(8'd33, 8'd25);

        // Reset in the low phase of bit 20.
        humidity_in    = 8'($urandom_range(0, 255));
        temperature_in = 8'($urandom_range(0, 255));
        exp_q.push_back(model_frame(humidity_in, temperature_in));
        host_start(2 * START * P);
        wait_bits(19, "reach_bit20");
        repeat (10) @(posedge clk);
        #2;
        check("bit20_low_driven", dht11_data, 0);
        reset_p = 1'b1;
        #2;
        check("reset_releases_bus_async", dht11_data, 1);
        check("reset_clears_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset_p = 1'b0;
        repeat (10) @(posedge clk);
        check("abort_queue_drained", exp_q.size(), 0);

        // Recovery and a random frame.
        do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        check("queue_empty", exp_q.size(), 0);
        check("frame_done_count", done_cnt, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
